c2c_master_ctrl: RTL

C2C_MASTER_CTRL -- requirements
Module: c2c_master_ctrl

---
 rtl/c2c_master_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/c2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// c2c_master_ctrl
//   Chip-to-chip transfer master. A start pulse samples the one-hot switch
//   bank, encodes the active switch as a 3-bit index and runs a four-phase
//   request/acknowledge handshake with the slave chip:
//     IDLE -> WAIT_ACK (request high) -> HOLD (data held HOLD_CYC cycles)
//          -> WAIT_REL (wait for ack release) -> DONE (done pulse) -> IDLE
//   A missing acknowledge aborts the transfer after TIMEOUT_CYC cycles.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed in WAIT_ACK before the transfer is aborted
//   HOLD_CYC     cycles data is held stable after the acknowledge is seen
//
// Ports
//   clk      in   system clock, all state on the rising edge
//   rst      in   asynchronous, active-high reset
//   start    in   one-cycle pulse requesting a transfer
//   sw[7:0]  in   switch bank, one-hot expected
//   ack      in   acknowledge from the slave, asynchronous to clk
//   request  out  request line to the slave
//   data[2:0]out  encoded switch index; keeps the last value sent while idle
//   busy     out  high whenever the controller is not in IDLE
//   done     out  one-cycle pulse on a completed transfer
//   timeout  out  one-cycle pulse on an aborted transfer
//   err      out  one-cycle pulse on a rejected start (C2C_ONEHOT_CHECK_EN)
//
// Build option
//   C2C_ONEHOT_CHECK_EN  when defined, a start with a non-one-hot switch value
//                        is rejected and flagged on err; otherwise such a
//                        value is sent as index 0.
// ---------------------------------------------------------------------------
module c2c_master_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned HOLD_CYC    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sw,
  input  logic       ack,
  output logic       request,
  output logic [2:0] data,
  output logic       busy,
  output logic       done,
  output logic       timeout
`ifdef C2C_ONEHOT_CHECK_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    HOLD,
    WAIT_REL,
    DONE
  } state_e;

  // Last counter value of each timed state; a zero parameter behaves as one.
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
  localparam logic [31:0] HOLD_LAST    = (HOLD_CYC > 0)    ? 32'(HOLD_CYC - 1)    : 32'd0;

  state_e      state_q;
  logic        ack_meta_q;
  logic        ack_s_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        request_q;
  logic [2:0]  data_q;
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic [2:0]  sw_idx;
  logic        start_ok;

  // Switch encoder: a lone set bit gives its index, anything else gives 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    sw_idx = 3'd0;
    case (sw)
      8'b0000_0001: sw_idx = 3'd0;
      8'b0000_0010: sw_idx = 3'd1;
      8'b0000_0100: sw_idx = 3'd2;
      8'b0000_1000: sw_idx = 3'd3;
      8'b0001_0000: sw_idx = 3'd4;
      8'b0010_0000: sw_idx = 3'd5;
      8'b0100_0000: sw_idx = 3'd6;
      8'b1000_0000: sw_idx = 3'd7;
      default:      sw_idx = 3'd0;
    endcase
  end

`ifdef C2C_ONEHOT_CHECK_EN
  logic sw_onehot;
  logic err_q;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sw_onehot = (sw != 8'd0) && ((sw & (sw - 8'd1)) == 8'd0);
  assign start_ok  = sw_onehot;
  assign err       = err_q;
`else
  assign start_ok  = 1'b1;
`endif

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      cnt_q      <= 32'd0;
      request_q  <= 1'b0;
      data_q     <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef C2C_ONEHOT_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values; later assignments in this block simply
      // override the defaults below.
      ack_meta_q <= ack;
      ack_s_q    <= ack_meta_q;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= cnt_d;
`ifdef C2C_ONEHOT_CHECK_EN
      err_q      <= 1'b0;
`endif

      case (state_q)
        IDLE: begin
          if (start && start_ok) begin
            data_q    <= sw_idx;
            request_q <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= 32'd0;
            state_q   <= WAIT_ACK;
          end
`ifdef C2C_ONEHOT_CHECK_EN
          if (start && !sw_onehot) begin
            err_q <= 1'b1;
          end
`endif
        end

        WAIT_ACK: begin
          if (ack_s_q) begin
            request_q <= 1'b0;
            cnt_q     <= 32'd0;
            state_q   <= HOLD;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            request_q <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            cnt_q     <= 32'd0;
            state_q   <= IDLE;
          end
        end

        HOLD: begin
          if (cnt_q >= HOLD_LAST) begin
            cnt_q   <= 32'd0;
            state_q <= WAIT_REL;
          end
        end

        WAIT_REL: begin
          // The slave must release ack; there is deliberately no timeout here.
          if (!ack_s_q) begin
            done_q  <= 1'b1;
            cnt_q   <= 32'd0;
            state_q <= DONE;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          cnt_q   <= 32'd0;
          state_q <= IDLE;
        end

        default: begin
          request_q <= 1'b0;
          busy_q    <= 1'b0;
          cnt_q     <= 32'd0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign request = request_q;
  assign data    = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule
